// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA timing generator with a pixel-fetch pipeline. A pair of
//   horizontal/vertical counters walks the full raster. Fetch coordinates are
//   issued straight from the counters. Sync, display-enable and the start
//   pulses are delayed FETCH_LAT enabled cycles so that they line up with
//   pixel data returned by a source with that read latency. Everything
//   advances only on cycles with vga_clk_en=1.
//
// Ports
//   vga_clk_in           pixel clock
//   vga_rst_n            synchronous active-low reset (wins over vga_clk_en)
//   vga_clk_en           advance enable; low freezes all state
//   fetch_req            current counter position is an active pixel
//   fetch_x / fetch_y    column / line being fetched (raw counter values)
//   pix_red/grn/blu      pixel data, valid FETCH_LAT enabled cycles after
//                        the matching fetch_req
//   o_red/o_grn/o_blu    registered colour, zero outside the active area
//   Hsync / Vsync        sync outputs, active level set by H_POL / V_POL
//   de                   display enable, aligned with colour
//   line_start           one-cycle pulse on output pixel (0, y)
//   frame_start          one-cycle pulse on output pixel (0, 0)
//
// Fetch contract: fetch_req has no ready. The pixel source must accept an
// address on every enabled cycle where fetch_req=1 and return its data
// exactly FETCH_LAT enabled cycles later. Disabled cycles stretch that
// latency in real time but not in enabled-cycle count.
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int H_POL     = 0,
    parameter int V_POL     = 0,
    parameter int CNT_W     = 12,
    parameter int COLOR_W   = 4,
    parameter int FETCH_LAT = 2
) (
    input  logic               vga_clk_in,
    input  logic               vga_rst_n,
    input  logic               vga_clk_en,
    output logic               fetch_req,
    output logic [CNT_W-1:0]   fetch_x,
    output logic [CNT_W-1:0]   fetch_y,
    input  logic [COLOR_W-1:0] pix_red,
    input  logic [COLOR_W-1:0] pix_grn,
    input  logic [COLOR_W-1:0] pix_blu,
    output logic [COLOR_W-1:0] o_red,
    output logic [COLOR_W-1:0] o_grn,
    output logic [COLOR_W-1:0] o_blu,
    output logic               Hsync,
    output logic               Vsync,
    output logic               de,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    // Active level of each sync output.
    localparam logic H_LVL = (H_POL != 0);
    localparam logic V_LVL = (V_POL != 0);

    generate
        if (FETCH_LAT < 0 || FETCH_LAT > 7) begin : g_bad_fetch_lat
            $error("vga_timing_gen: FETCH_LAT must be in 0..7");
        end
        if (longint'(H_TOTAL) > (longint'(1) << CNT_W)) begin : g_bad_h_total
            $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
        end
        if (longint'(V_TOTAL) > (longint'(1) << CNT_W)) begin : g_bad_v_total
            $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             w_h_last;
    logic             w_v_last;

    assign w_h_last = (int'(r_h_cnt) == H_TOTAL - 1);
    assign w_v_last = (int'(r_v_cnt) == V_TOTAL - 1);

    always_ff @(posedge vga_clk_in) begin
        if (!vga_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (vga_clk_en) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + CNT_W'(1);
            end else begin
                r_h_cnt <= r_h_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: decode straight from the counters
    // ------------------------------------------------------------------
    logic w_hs_raw;
    logic w_vs_raw;
    logic w_de_raw;
    logic w_ls_raw;
    logic w_fs_raw;

    assign w_de_raw = (int'(r_h_cnt) < H_ACTIVE) && (int'(r_v_cnt) < V_ACTIVE);
    // Sync bits are carried active-high internally; polarity is applied
    // only at the output register so the cleared delay line means "inactive".
    assign w_hs_raw = (int'(r_h_cnt) >= HS_START) && (int'(r_h_cnt) < HS_END);
    // Vertical sync depends on the line count only, so its edges land on h_cnt=0.
    assign w_vs_raw = (int'(r_v_cnt) >= VS_START) && (int'(r_v_cnt) < VS_END);
    assign w_ls_raw = (r_h_cnt == '0);
    assign w_fs_raw = (r_h_cnt == '0) && (r_v_cnt == '0);

    assign fetch_req = w_de_raw;
    assign fetch_x   = r_h_cnt;
    assign fetch_y   = r_v_cnt;

    // ------------------------------------------------------------------
    // Delay line matching the pixel-source latency
    // bit 4 hsync, 3 vsync, 2 de, 1 line_start, 0 frame_start
    // ------------------------------------------------------------------
    logic [4:0] w_raw;
    logic [4:0] w_dly;

    assign w_raw = {w_hs_raw, w_vs_raw, w_de_raw, w_ls_raw, w_fs_raw};

    generate
        if (FETCH_LAT == 0) begin : g_no_dly
            assign w_dly = w_raw;
        end else begin : g_dly
            logic [4:0] r_pipe [FETCH_LAT];

            always_ff @(posedge vga_clk_in) begin
                if (!vga_rst_n) begin
                    for (int i = 0; i < FETCH_LAT; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else if (vga_clk_en) begin
                    r_pipe[0] <= w_raw;
                    for (int i = 1; i < FETCH_LAT; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_dly = r_pipe[FETCH_LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clk_in) begin
        if (!vga_rst_n) begin
            Hsync       <= ~H_LVL;
            Vsync       <= ~V_LVL;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            o_red       <= '0;
            o_grn       <= '0;
            o_blu       <= '0;
        end else if (vga_clk_en) begin
            Hsync       <= ~(w_dly[4] ^ H_LVL);
            Vsync       <= ~(w_dly[3] ^ V_LVL);
            de          <= w_dly[2];
            line_start  <= w_dly[1];
            frame_start <= w_dly[0];
            o_red       <= w_dly[2] ? pix_red : '0;
            o_grn       <= w_dly[2] ? pix_grn : '0;
            o_blu       <= w_dly[2] ? pix_blu : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Three instances share clock, reset and enable:
//     d=0 : tiny raster, active-high syncs, FETCH_LAT=0 (8 x 5, 40-cycle frame)
//     d=1 : small raster, active-low syncs, FETCH_LAT=2 (23 x 10, 230-cycle frame)
//     d=2 : default 640x480 timing, only the first few lines are exercised
//   Each enabled cycle pushes the expected output record for the current
//   model raster position into a per-instance queue; the record popped
//   after the edge is what the outputs must show.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic en;

    int checks   = 0;
    int failures = 0;

    // ---------------- per-instance geometry ----------------
    localparam int HA  [3] = '{4, 16, 640};
    localparam int HFP [3] = '{1, 2, 16};
    localparam int HSW [3] = '{2, 3, 96};
    localparam int HBP [3] = '{1, 2, 48};
    localparam int VA  [3] = '{2, 6, 480};
    localparam int VFP [3] = '{1, 1, 10};
    localparam int VSW [3] = '{1, 2, 2};
    localparam int VBP [3] = '{1, 1, 33};
    localparam int HPL [3] = '{1, 0, 0};
    localparam int VPL [3] = '{1, 0, 0};
    localparam int LAT [3] = '{0, 2, 2};

    // ---------------- DUT signals ----------------
    logic        freq_a, freq_b, freq_c;
    logic [11:0] fx_a, fy_a, fx_b, fy_b, fx_c, fy_c;
    logic [3:0]  pr_a, pg_a, pb_a, pr_b, pg_b, pb_b, pr_c, pg_c, pb_c;
    logic [3:0]  or_a, og_a, ob_a, or_b, og_b, ob_b, or_c, og_c, ob_c;
    logic        hs_a, vs_a, de_a, ls_a, fs_a;
    logic        hs_b, vs_b, de_b, ls_b, fs_b;
    logic        hs_c, vs_c, de_c, ls_c, fs_c;

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1), .V_POL(1), .CNT_W(12), .COLOR_W(4), .FETCH_LAT(0)
    ) dut_a (
        .vga_clk_in(clk), .vga_rst_n(rst_n), .vga_clk_en(en),
        .fetch_req(freq_a), .fetch_x(fx_a), .fetch_y(fy_a),
        .pix_red(pr_a), .pix_grn(pg_a), .pix_blu(pb_a),
        .o_red(or_a), .o_grn(og_a), .o_blu(ob_a),
        .Hsync(hs_a), .Vsync(vs_a), .de(de_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(0), .V_POL(0), .CNT_W(12), .COLOR_W(4), .FETCH_LAT(2)
    ) dut_b (
        .vga_clk_in(clk), .vga_rst_n(rst_n), .vga_clk_en(en),
        .fetch_req(freq_b), .fetch_x(fx_b), .fetch_y(fy_b),
        .pix_red(pr_b), .pix_grn(pg_b), .pix_blu(pb_b),
        .o_red(or_b), .o_grn(og_b), .o_blu(ob_b),
        .Hsync(hs_b), .Vsync(vs_b), .de(de_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    vga_timing_gen dut_c (
        .vga_clk_in(clk), .vga_rst_n(rst_n), .vga_clk_en(en),
        .fetch_req(freq_c), .fetch_x(fx_c), .fetch_y(fy_c),
        .pix_red(pr_c), .pix_grn(pg_c), .pix_blu(pb_c),
        .o_red(or_c), .o_grn(og_c), .o_blu(ob_c),
        .Hsync(hs_c), .Vsync(vs_c), .de(de_c),
        .line_start(ls_c), .frame_start(fs_c)
    );

    // ---------------- pixel sources ----------------
    // Pixel value = {x[3:0], y[3:0], 4'hA}, returned after the instance's latency.
    assign pr_a = fx_a[3:0];
    assign pg_a = fy_a[3:0];
    assign pb_a = 4'hA;

    logic [11:0] mem_b1, mem_b2, mem_c1, mem_c2;
    always @(posedge clk) begin
        if (rst_n && en) begin
            mem_b1 <= {fx_b[3:0], fy_b[3:0], 4'hA};
            mem_b2 <= mem_b1;
            mem_c1 <= {fx_c[3:0], fy_c[3:0], 4'hA};
            mem_c2 <= mem_c1;
        end
    end
    assign {pr_b, pg_b, pb_b} = mem_b2;
    assign {pr_c, pg_c, pb_c} = mem_c2;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    exp_t exp_q2[$];
    exp_t cur [3];
    int   mh  [3];
    int   mv  [3];
    int   kcnt;

    function automatic exp_t idle(input int d);
        exp_t e;
        e    = '0;
        e.hs = (HPL[d] == 0);
        e.vs = (VPL[d] == 0);
        return e;
    endfunction

    function automatic exp_t model_raw(input int d, input int h, input int v);
        exp_t e;
        logic hs_on;
        logic vs_on;
        hs_on = (h >= HA[d] + HFP[d]) && (h < HA[d] + HFP[d] + HSW[d]);
        vs_on = (v >= VA[d] + VFP[d]) && (v < VA[d] + VFP[d] + VSW[d]);
        e.hs  = hs_on ? (HPL[d] != 0) : (HPL[d] == 0);
        e.vs  = vs_on ? (VPL[d] != 0) : (VPL[d] == 0);
        e.de  = (h < HA[d]) && (v < VA[d]);
        e.ls  = (h == 0);
        e.fs  = (h == 0) && (v == 0);
        e.r   = e.de ? h[3:0] : 4'h0;
        e.g   = e.de ? v[3:0] : 4'h0;
        e.b   = e.de ? 4'hA : 4'h0;
        return e;
    endfunction

    function automatic exp_t get_act(input int d);
        case (d)
            0:       return {hs_a, vs_a, de_a, ls_a, fs_a, or_a, og_a, ob_a};
            1:       return {hs_b, vs_b, de_b, ls_b, fs_b, or_b, og_b, ob_b};
            default: return {hs_c, vs_c, de_c, ls_c, fs_c, or_c, og_c, ob_c};
        endcase
    endfunction

    function automatic logic [24:0] get_fetch(input int d);
        case (d)
            0:       return {freq_a, fx_a, fy_a};
            1:       return {freq_b, fx_b, fy_b};
            default: return {freq_c, fx_c, fy_c};
        endcase
    endfunction

    task automatic sb_clear(input int d);
        case (d)
            0:       exp_q0.delete();
            1:       exp_q1.delete();
            default: exp_q2.delete();
        endcase
    endtask

    task automatic sb_push(input int d, input exp_t e);
        case (d)
            0:       exp_q0.push_back(e);
            1:       exp_q1.push_back(e);
            default: exp_q2.push_back(e);
        endcase
    endtask

    task automatic sb_pop(input int d, output exp_t e);
        e = idle(d);
        case (d)
            0:       if (exp_q0.size() > 0) e = exp_q0.pop_front();
            1:       if (exp_q1.size() > 0) e = exp_q1.pop_front();
            default: if (exp_q2.size() > 0) e = exp_q2.pop_front();
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- line / frame measurement state ----------------
    int   c_ls_age, c_de_cnt, c_lw, b_fs_age;
    bit   c_ls_seen, c_fall_seen, b_fs_seen;
    logic c_prev_hs;

    // One clock: drive inputs, let the edge happen, update the model,
    // then compare on the falling edge.
    task automatic tick(input logic r, input logic e);
        exp_t x;
        rst_n = r;
        en    = e;
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (!r) begin
                sb_clear(d);
                for (int i = 0; i < LAT[d]; i++) sb_push(d, idle(d));
                cur[d] = idle(d);
                mh[d]  = 0;
                mv[d]  = 0;
            end else if (e) begin
                sb_push(d, model_raw(d, mh[d], mv[d]));
                sb_pop(d, x);
                cur[d] = x;
                if (mh[d] == HA[d] + HFP[d] + HSW[d] + HBP[d] - 1) begin
                    mh[d] = 0;
                    mv[d] = (mv[d] == VA[d] + VFP[d] + VSW[d] + VBP[d] - 1) ? 0 : mv[d] + 1;
                end else begin
                    mh[d] = mh[d] + 1;
                end
            end
        end
        if (!r) kcnt = 0;
        else if (e) kcnt++;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("sb_out%0d", d), 32'(get_act(d)), 32'(cur[d]));
            chk($sformatf("sb_fetch%0d", d), 32'(get_fetch(d)),
                32'({(mh[d] < HA[d]) && (mv[d] < VA[d]), 12'(mh[d]), 12'(mv[d])}));
        end
        if (!r) begin
            c_ls_seen   = 0;
            c_fall_seen = 0;
            c_prev_hs   = 1'b1;
            b_fs_seen   = 0;
        end else if (e) begin
            c_ls_age++;
            c_lw++;
            if (ls_c) begin
                if (c_ls_seen) chk("c_de_per_line", c_de_cnt, 640);
                c_de_cnt  = 0;
                c_ls_age  = 0;
                c_ls_seen = 1;
            end
            if (de_c) c_de_cnt++;
            if (c_prev_hs && !hs_c) begin
                if (c_ls_seen) chk("c_hsync_fall_after_ls", c_ls_age, 656);
                c_lw        = 0;
                c_fall_seen = 1;
            end
            if (!c_prev_hs && hs_c && c_fall_seen) chk("c_hsync_low_width", c_lw, 96);
            c_prev_hs = hs_c;
            b_fs_age++;
            if (fs_b) begin
                if (b_fs_seen) chk("b_frame_period", b_fs_age, 230);
                b_fs_age  = 0;
                b_fs_seen = 1;
            end
        end
    endtask

    // ---------------- table for the tiny raster (d=0) ----------------
    typedef struct {
        int         k;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic [3:0] r;
        logic [3:0] g;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int n;
        // k = enabled edge index after reset release; output shows (k%8, (k/8)%5)
        tbl[0]  = '{0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0};
        tbl[1]  = '{3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0};
        tbl[2]  = '{4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
        tbl[3]  = '{5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
        tbl[4]  = '{6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
        tbl[5]  = '{7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
        tbl[6]  = '{8,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1};
        tbl[7]  = '{10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd1};
        tbl[8]  = '{16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0};
        tbl[9]  = '{24, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0};
        tbl[10] = '{31, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};
        tbl[11] = '{32, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0};
        tbl[12] = '{40, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0};
        tbl[13] = '{45, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0};

        rst_n = 1'b0;
        en    = 1'b0;

        // Reset with enable low must still take effect.
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("rst_hsync_a", hs_a, 0);
        chk("rst_vsync_a", vs_a, 0);
        chk("rst_hsync_b", hs_b, 1);
        chk("rst_vsync_b", vs_b, 1);
        chk("rst_de_b", de_b, 0);
        chk("rst_red_b", or_b, 0);
        chk("rst_fs_b", fs_b, 0);
        chk("rst_fetch_c", {freq_c, fx_c, fy_c}, {1'b1, 12'd0, 12'd0});
        tick(1'b0, 1'b1);

        // Tiny raster: table of hand-derived output values.
        for (int i = 0; i < 14; i++) begin
            while (kcnt < tbl[i].k + 1) tick(1'b1, 1'b1);
            chk($sformatf("tbl_k%0d_ctl", tbl[i].k), {hs_a, vs_a, de_a, ls_a, fs_a},
                {tbl[i].hs, tbl[i].vs, tbl[i].de, tbl[i].ls, tbl[i].fs});
            chk($sformatf("tbl_k%0d_rgb", tbl[i].k), {or_a, og_a, ob_a},
                {tbl[i].r, tbl[i].g, tbl[i].de ? 4'hA : 4'h0});
        end

        // Continuous enable: several frames of d=1, a couple of lines of d=2.
        repeat (1700) tick(1'b1, 1'b1);

        // Pseudo-random enable gating.
        repeat (600) tick(1'b1, 1'($urandom_range(0, 1)));

        // Mid-frame reset on d=1 at h=10, v=3.
        n = 0;
        while (!(mh[1] == 10 && mv[1] == 3) && n < 600) begin
            tick(1'b1, 1'b1);
            n++;
        end
        chk("mid_position_reached", (mh[1] == 10 && mv[1] == 3), 1);
        tick(1'b0, 1'b1);
        chk("mr_hsync_b", hs_b, 1);
        chk("mr_vsync_b", vs_b, 1);
        chk("mr_de_b", de_b, 0);
        chk("mr_rgb_b", {or_b, og_b, ob_b}, 0);
        chk("mr_fetch_b", {fx_b, fy_b}, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1);
            chk($sformatf("mr_fs_b_%0d", i), fs_b, (i == 2));
        end

        // Wrap corner on d=1: h=22, v=9.
        n = 0;
        while (!(mh[1] == 22 && mv[1] == 9) && n < 600) begin
            tick(1'b1, 1'b1);
            n++;
        end
        chk("wrap_position_reached", (mh[1] == 22 && mv[1] == 9), 1);
        tick(1'b1, 1'b1);
        chk("wrap_fetch_b", {freq_b, fx_b, fy_b}, {1'b1, 12'd0, 12'd0});
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        chk("wrap_fs_early_b", fs_b, 0);
        tick(1'b1, 1'b1);
        chk("wrap_fs_ls_b", {fs_b, ls_b}, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
